frogger_game_ctrl: RTL and testbench
====================================

Name: frogger_game_ctrl

Overview:
Game sequencer for the Frogger datapath. It debounces the raw active-low pushbuttons and turns each press into a one-cycle move pulse. It schedules the lane-shift tick, with the tick rate rising per level. It runs the play/death/win/game-over state machine that commands frog and lane re-initialisation. It sits between the board buttons and the frogger logic/VGA writer, and replaces their free-running one-second shift and direct button wiring.

Parameters:
TICK_BASE, 100000000, clk cycles between lane shifts at level 0
TICK_STEP, 12500000, cycles removed from the tick period per level; must satisfy TICK_BASE > MAX_LEVEL*TICK_STEP
DEBOUNCE, 1000000, cycles a synchronised button must stay stable before its debounced level changes
HOLD, 50000000, cycles spent in DYING or WON before continuing
LIVES, 3, lives granted at game start (1..3)
MAX_LEVEL, 7, highest level (level width 3 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low; low clears all state immediately
btn_up, btn_down, btn_left, btn_right  in  1 each  raw buttons, active-low, asynchronous to clk
btn_start  in  1  raw start button, active-low
collide  in  1  from datapath: frog occupies a car cell this cycle
at_top  in  1  from datapath: frog vertical state == 0
mv_up, mv_down, mv_left, mv_right  out  1 each  one-cycle move pulses
lane_shift  out  1  one-cycle pulse: shift all car rows once
lanes_init  out  1  one-cycle pulse: load car rows with initial patterns
frog_home  out  1  one-cycle pulse: frog to row 7, column 8'b0001_0000
game_state  out  2  00 IDLE, 01 PLAY, 10 DYING, 11 WON
lives  out  2  remaining lives
level  out  3  current level
score  out  8  frogs delivered, saturating

Behaviour:
- Reset (low, async): game_state=IDLE; lives, level and score = 0. All pulses = 0. All counters = 0. Synchroniser and debounced levels = 1 (released).
- Per button: 2-flop synchroniser, then a counter that clears whenever the synchronised value differs from the debounced level.
  - When the counter reaches DEBOUNCE-1, the debounced level takes the synchronised value.
  - A press is a 1->0 transition of the debounced level.
  - Latency from a clean raw edge to the pulse: 2 + DEBOUNCE + 1 cycles.
  - Releases generate nothing. A held button gives exactly one press.
- Move pulses are registered, one cycle wide, and issued only in PLAY.
  - Priority when several presses land in one cycle: up > down > left > right. Losers are dropped.
  - Presses outside PLAY are discarded, not queued.
- Tick scheduler:
  - period = TICK_BASE - level*TICK_STEP. Counter width is $clog2(TICK_BASE).
  - In PLAY, the counter runs 0..period-1; lane_shift pulses on the cycle after it reaches period-1, then the counter wraps to 0.
  - Outside PLAY, the counter is held at 0 and no lane_shift is issued.
  - The counter clears whenever level changes.
- FSM:
  - IDLE: start press -> PLAY. Same cycle: lanes_init and frog_home pulse; lives=LIVES, level=0, score=0. Other buttons are ignored.
  - PLAY, collide=1 -> DYING, lives-1. collide wins over a simultaneous at_top.
  - PLAY, at_top=1 (collide=0) -> WON, score+1 saturating at 255.
  - PLAY, btn_start -> ignored.
  - DYING: hold counter runs 0..HOLD-1. At the end: if lives==0 -> IDLE (game over, lives/level/score frozen for display). Otherwise frog_home pulses -> PLAY; lanes keep their positions.
  - WON: hold counter runs 0..HOLD-1. At the end: level = min(level+1, MAX_LEVEL); frog_home and lanes_init pulse -> PLAY.
  - The hold counter clears on entry to DYING and WON.
  - collide and at_top are ignored outside PLAY.
- All outputs are registered. A pulse caused by an event in cycle N is high in cycle N+1 only.
- No lane_shift and no move pulse occur in the cycle in which the state leaves PLAY.
- Reset asserted at any point, including mid-hold or mid-debounce, forces the reset values asynchronously. After release, the block resumes in IDLE.

Test Plan:
Bench parameters for all scenarios: TICK_BASE=10, TICK_STEP=2, DEBOUNCE=4, HOLD=5, LIVES=2, MAX_LEVEL=3.
1. Reset low 3 cycles, then high; hold btn_start low 10 cycles -> one lanes_init and one frog_home pulse, 7 cycles after the raw edge; game_state=01, lives=2, level=0, score=0.
2. In PLAY at level 0 -> lane_shift every 10 cycles. Force at_top=1 for one cycle -> WON for 5 cycles, then level=1 and lane_shift every 8 cycles.
3. btn_up toggled every 2 cycles for 12 cycles, then held low -> exactly one mv_up. btn_up and btn_left debounced low in the same cycle -> mv_up only.
4. collide=1 and at_top=1 in the same cycle -> DYING, lives=1, score unchanged; after 5 cycles frog_home pulses and state returns to PLAY. A second collide -> lives=0; after the hold, game_state=00 and no frog_home.
5. Four successive wins from level 0 -> level saturates at 3, score=4, lane_shift period 4 cycles.
6. Reset driven low in the middle of DYING -> game_state=00 and all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frogger_game_ctrl
// Description : Frogger game sequencer. Debounces the active-low buttons into
//               one-cycle move pulses, schedules the level-dependent lane
//               shift tick and runs the IDLE/PLAY/DYING/WON state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module frogger_game_ctrl #(
    parameter int TICK_BASE = 100000000,
    parameter int TICK_STEP = 12500000,
    parameter int DEBOUNCE  = 1000000,
    parameter int HOLD      = 50000000,
    parameter int LIVES     = 3,
    parameter int MAX_LEVEL = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       collide,
    input  logic       at_top,
    output logic       mv_up,
    output logic       mv_down,
    output logic       mv_left,
    output logic       mv_right,
    output logic       lane_shift,
    output logic       lanes_init,
    output logic       frog_home,
    output logic [1:0] game_state,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [7:0] score
);

    localparam int c_TICK_W = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
    localparam int c_DB_W   = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
    localparam int c_HOLD_W = (HOLD      > 1) ? $clog2(HOLD)      : 1;
    localparam int c_NBTN   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_DYING = 2'b10,
        S_WON   = 2'b11
    } state_t;

    // Button index: 0 up, 1 down, 2 left, 3 right, 4 start
    logic [c_NBTN-1:0] w_raw;
    logic [c_NBTN-1:0] w_press;

    assign w_raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < c_NBTN; i++) begin : g_btn
        logic [1:0]        r_sync;
        logic [c_DB_W-1:0] r_cnt;
        logic              r_deb;
        logic              r_deb_d;

        // Synchronise, then accept a new level only after it has been stable
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync  <= 2'b11;
                r_cnt   <= '0;
                r_deb   <= 1'b1;
                r_deb_d <= 1'b1;
            end else begin
                r_sync  <= {r_sync[0], w_raw[i]};
                r_deb_d <= r_deb;
                if (r_sync[1] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_W'(DEBOUNCE - 1)) begin
                    r_deb <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // A press is the falling edge of the debounced level
        assign w_press[i] = r_deb_d & ~r_deb;
    end

    state_t                r_state;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_TICK_W-1:0]   w_period_m1;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [1:0]            r_lives;
    logic [2:0]            r_level;
    logic [7:0]            r_score;
    logic                  r_mv_up, r_mv_down, r_mv_left, r_mv_right;
    logic                  r_lane_shift, r_lanes_init, r_frog_home;

    // Last count of the lane-shift period for the current level
    always_comb begin
        w_period_m1 = c_TICK_W'(TICK_BASE - 1 - int'(r_level) * TICK_STEP);
    end

    // Game state machine, tick scheduler and registered output pulses.
    // Level only changes outside PLAY, where the tick counter is held at 0,
    // so a level change always restarts the tick period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_lives      <= '0;
            r_level      <= '0;
            r_score      <= '0;
            r_mv_up      <= 1'b0;
            r_mv_down    <= 1'b0;
            r_mv_left    <= 1'b0;
            r_mv_right   <= 1'b0;
            r_lane_shift <= 1'b0;
            r_lanes_init <= 1'b0;
            r_frog_home  <= 1'b0;
        end else begin
            r_mv_up      <= 1'b0;
            r_mv_down    <= 1'b0;
            r_mv_left    <= 1'b0;
            r_mv_right   <= 1'b0;
            r_lane_shift <= 1'b0;
            r_lanes_init <= 1'b0;
            r_frog_home  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tick_cnt <= '0;
                    if (w_press[4]) begin
                        r_state      <= S_PLAY;
                        r_lanes_init <= 1'b1;
                        r_frog_home  <= 1'b1;
                        r_lives      <= 2'(LIVES);
                        r_level      <= '0;
                        r_score      <= '0;
                    end
                end
                S_PLAY: begin
                    if (collide) begin
                        r_state    <= S_DYING;
                        r_lives    <= r_lives - 2'd1;
                        r_hold_cnt <= '0;
                        r_tick_cnt <= '0;
                    end else if (at_top) begin
                        r_state    <= S_WON;
                        if (r_score != 8'hFF) begin
                            r_score <= r_score + 8'd1;
                        end
                        r_hold_cnt <= '0;
                        r_tick_cnt <= '0;
                    end else begin
                        if (w_press[0]) begin
                            r_mv_up <= 1'b1;
                        end else if (w_press[1]) begin
                            r_mv_down <= 1'b1;
                        end else if (w_press[2]) begin
                            r_mv_left <= 1'b1;
                        end else if (w_press[3]) begin
                            r_mv_right <= 1'b1;
                        end
                        if (r_tick_cnt == w_period_m1) begin
                            r_tick_cnt   <= '0;
                            r_lane_shift <= 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DYING: begin
                    r_tick_cnt <= '0;
                    if (r_hold_cnt == c_HOLD_W'(HOLD - 1)) begin
                        r_hold_cnt <= '0;
                        if (r_lives == 2'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state     <= S_PLAY;
                            r_frog_home <= 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_WON: begin
                    r_tick_cnt <= '0;
                    if (r_hold_cnt == c_HOLD_W'(HOLD - 1)) begin
                        r_hold_cnt   <= '0;
                        r_state      <= S_PLAY;
                        r_frog_home  <= 1'b1;
                        r_lanes_init <= 1'b1;
                        if (r_level < 3'(MAX_LEVEL)) begin
                            r_level <= r_level + 3'd1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mv_up      = r_mv_up;
    assign mv_down    = r_mv_down;
    assign mv_left    = r_mv_left;
    assign mv_right   = r_mv_right;
    assign lane_shift = r_lane_shift;
    assign lanes_init = r_lanes_init;
    assign frog_home  = r_frog_home;
    assign game_state = r_state;
    assign lives      = r_lives;
    assign level      = r_level;
    assign score      = r_score;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frogger_game_ctrl
// Description : Scoreboard bench for frogger_game_ctrl. Stimulus pushes the
//               expected pulse/state events, a negedge monitor pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frogger_game_ctrl;

    localparam logic [6:0] c_UP = 7'b1000000;
    localparam logic [6:0] c_LS = 7'b0000100;
    localparam logic [6:0] c_LI = 7'b0000010;
    localparam logic [6:0] c_FH = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
    logic btn_start = 1'b1;
    logic collide = 1'b0, at_top = 1'b0;
    logic mv_up, mv_down, mv_left, mv_right, lane_shift, lanes_init, frog_home;
    logic [1:0] game_state, lives;
    logic [2:0] level;
    logic [7:0] score;

    frogger_game_ctrl #(
        .TICK_BASE(10), .TICK_STEP(2), .DEBOUNCE(4),
        .HOLD(5), .LIVES(2), .MAX_LEVEL(3)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_start(btn_start),
        .collide(collide), .at_top(at_top),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .lane_shift(lane_shift), .lanes_init(lanes_init), .frog_home(frog_home),
        .game_state(game_state), .lives(lives), .level(level), .score(score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] p;
        logic [1:0] st;
        logic [1:0] lv;
        logic [2:0] lvl;
        logic [7:0] sc;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic void push(int c, logic [6:0] p, logic [1:0] st,
                                 logic [1:0] lv, logic [2:0] lvl, logic [7:0] sc);
        exp_t e;
        int pos;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].c == c) begin
                q[i].p = q[i].p | p;
                return;
            end
            if (q[i].c > c) begin
                pos = i;
                break;
            end
        end
        e.c = c; e.p = p; e.st = st; e.lv = lv; e.lvl = lvl; e.sc = sc;
        q.insert(pos, e);
    endfunction

    function automatic void push_shifts(int e, int x, int per, logic [1:0] lv,
                                        logic [2:0] lvl, logic [7:0] sc);
        for (int c = e + per; c < x; c += per) push(c, c_LS, 2'b01, lv, lvl, sc);
    endfunction

    task automatic check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) step(1);
    endtask

    // Drive collide/at_top for exactly the cycle whose edge is x
    task automatic pulse_in(int x, logic col, logic top);
        wait_until(x - 1);
        collide = col;
        at_top  = top;
        step(1);
        collide = 1'b0;
        at_top  = 1'b0;
    endtask

    // Monitor: any pulse or state change is an event to score
    logic [1:0] prev_st = 2'b00;
    always @(negedge clk) begin
        logic [6:0] act;
        exp_t e;
        act = {mv_up, mv_down, mv_left, mv_right, lane_shift, lanes_init, frog_home};
        if (act != 7'd0 || game_state != prev_st) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event cyc=%0d pulses=%b state=%b lives=%0d level=%0d score=%0d",
                         cyc, act, game_state, lives, level, score);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.p != act || e.st != game_state || e.lv != lives ||
                    e.lvl != level || e.sc != score) begin
                    miscompares++;
                    $display("FAIL event actual cyc=%0d pulses=%b state=%b lives=%0d level=%0d score=%0d required cyc=%0d pulses=%b state=%b lives=%0d level=%0d score=%0d",
                             cyc, act, game_state, lives, level, score,
                             e.c, e.p, e.st, e.lv, e.lvl, e.sc);
                end
            end
        end
        prev_st = game_state;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p, e, x;
        logic [6:0] pv;

        // Reset state
        step(3);
        pv = {mv_up, mv_down, mv_left, mv_right, lane_shift, lanes_init, frog_home};
        check("rst_state", game_state, 0);
        check("rst_lives", lives, 0);
        check("rst_level", level, 0);
        check("rst_score", score, 0);
        check("rst_pulses", pv, 0);
        reset = 1'b1;
        step(2);

        // Start: pulse 7 cycles after the raw edge, then WON from level 0
        p = cyc;
        e = p + 7;
        x = e + 35;
        push(e, c_LI | c_FH, 2'b01, 2'd2, 3'd0, 8'd0);
        push_shifts(e, x, 10, 2'd2, 3'd0, 8'd0);
        push(x, 7'd0, 2'b11, 2'd2, 3'd0, 8'd1);
        btn_start = 1'b0;
        step(10);
        btn_start = 1'b1;
        pulse_in(x, 1'b0, 1'b1);

        // Level 1: bounced button, dual press, collide beats at_top
        e = x + 5;
        x = e + 53;
        push(e, c_LI | c_FH, 2'b01, 2'd2, 3'd1, 8'd1);
        push_shifts(e, x, 8, 2'd2, 3'd1, 8'd1);
        push(e + 21, c_UP, 2'b01, 2'd2, 3'd1, 8'd1);
        push(e + 41, c_UP, 2'b01, 2'd2, 3'd1, 8'd1);
        push(x, 7'd0, 2'b10, 2'd1, 3'd1, 8'd1);
        wait_until(e + 2);
        for (int i = 0; i < 6; i++) begin
            btn_up = i[0];
            step(2);
        end
        btn_up = 1'b0;
        step(10);
        btn_up = 1'b1;
        wait_until(e + 34);
        btn_up   = 1'b0;
        btn_left = 1'b0;
        step(10);
        btn_up   = 1'b1;
        btn_left = 1'b1;
        pulse_in(x, 1'b1, 1'b1);

        // Back to PLAY with one life, then game over
        e = x + 5;
        x = e + 20;
        push(e, c_FH, 2'b01, 2'd1, 3'd1, 8'd1);
        push_shifts(e, x, 8, 2'd1, 3'd1, 8'd1);
        push(x, 7'd0, 2'b10, 2'd0, 3'd1, 8'd1);
        push(x + 5, 7'd0, 2'b00, 2'd0, 3'd1, 8'd1);
        pulse_in(x, 1'b1, 1'b0);
        wait_until(x + 6);
        btn_down = 1'b0;
        step(10);
        btn_down = 1'b1;
        step(8);

        // Four wins: level saturates at 3
        p = cyc;
        e = p + 7;
        push(e, c_LI | c_FH, 2'b01, 2'd2, 3'd0, 8'd0);
        btn_start = 1'b0;
        step(6);
        btn_start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            x = e + 3;
            push(x, 7'd0, 2'b11, 2'd2, 3'((i - 1 > 3) ? 3 : i - 1), 8'(i));
            e = x + 5;
            push(e, c_LI | c_FH, 2'b01, 2'd2, 3'((i > 3) ? 3 : i), 8'(i));
            pulse_in(x, 1'b0, 1'b1);
        end

        // Period 4 at level 3, then reset in the middle of DYING
        x = e + 18;
        push_shifts(e, x, 4, 2'd2, 3'd3, 8'd4);
        push(x, 7'd0, 2'b10, 2'd1, 3'd3, 8'd4);
        pulse_in(x, 1'b1, 1'b0);
        wait_until(x + 2);
        push(x + 2, 7'd0, 2'b00, 2'd0, 3'd0, 8'd0);
        reset = 1'b0;
        #2;
        pv = {mv_up, mv_down, mv_left, mv_right, lane_shift, lanes_init, frog_home};
        check("async_state", game_state, 0);
        check("async_lives", lives, 0);
        check("async_level", level, 0);
        check("async_score", score, 0);
        check("async_pulses", pv, 0);
        step(2);
        reset = 1'b1;
        step(10);
        check("post_reset_state", game_state, 0);

        while (q.size() > 0) begin
            exp_t m;
            m = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event actual=none required cyc=%0d pulses=%b state=%b",
                     m.c, m.p, m.st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
